// File: rtl/game_flow_controller_if.sv
// Signal bundle between the Pong game flow controller and its neighbours:
// coin/start switches, video timing, ball/miss logic and the score counters.
// The master side drives the inputs; the controller sits on the slave side.
interface game_flow_controller_if;
  logic       vblank;
  logic       coin;
  logic       start;
  logic       miss;
  logic       miss_r;
  logic       stop_g;
  logic       srst;
  logic       _srst;
  logic       l;
  logic       r;
  logic       serve;
  logic       _attract;
  logic [3:0] credits;

  modport master (
    output vblank, coin, start, miss, miss_r, stop_g,
    input  srst, _srst, l, r, serve, _attract, credits
  );

  modport slave (
    input  vblank, coin, start, miss, miss_r, stop_g,
    output srst, _srst, l, r, serve, _attract, credits
  );
endinterface

// File: rtl/game_flow_controller.sv
// Game flow sequencer for the Pong score datapath: credit bookkeeping,
// start handling, score clear, serve delay, miss-to-point conversion and
// end-of-game detection. All outputs are registered.
// Optional feature: define FREE_PLAY_EN to accept start without credits
// (credits then only count coins and never decrement).
module game_flow_controller #(
  parameter int SERVE_FRAMES = 60,
  parameter int OVER_FRAMES  = 180,
  parameter int SRST_CYCLES  = 4,
  parameter int CREDIT_MAX   = 9
) (
  input logic              clk7_159,
  input logic              _reset,
  game_flow_controller_if.slave bus
);

  typedef enum logic [2:0] {
    ATTRACT,
    START_RST,
    SERVE_WAIT,
    PLAY,
    POINT,
    GAME_OVER
  } state_t;

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] OVER_LAST  = 8'(OVER_FRAMES - 1);
  localparam logic [3:0] SRST_LAST  = 4'(SRST_CYCLES - 1);
  localparam logic [3:0] CRED_MAX   = 4'(CREDIT_MAX);

  state_t     state;
  logic [7:0] timer;
  logic [3:0] srst_cnt;
  logic       point_cnt;

  logic       coin_prev;
  logic       start_prev;
  logic       vblank_prev;

  logic       coin_edge;
  logic       start_edge;
  logic       frame_tick;
  logic       start_window;
  logic       accept;

  logic [3:0] credit_cnt;
  logic       clear;
  logic       clear_n;
  logic       strobe_l;
  logic       strobe_r;
  logic       serve_pulse;
  logic       game_on;

  // Credit counter saturating increment.
  function automatic logic [3:0] credit_inc(input logic [3:0] c);
    return (c >= CRED_MAX) ? CRED_MAX : c + 4'd1;
  endfunction

  // Credit counter decrement that never goes below zero.
  function automatic logic [3:0] credit_dec(input logic [3:0] c);
    return (c == 4'd0) ? 4'd0 : c - 4'd1;
  endfunction

  // Edge detection and start qualification from the current inputs.
  always_comb begin
    coin_edge    = bus.coin & ~coin_prev;
    start_edge   = bus.start & ~start_prev;
    frame_tick   = bus.vblank & ~vblank_prev;
    start_window = (state == ATTRACT) || (state == GAME_OVER);
`ifdef FREE_PLAY_EN
    accept       = start_edge & start_window;
`else
    accept       = start_edge & start_window & (credit_cnt != 4'd0);
`endif
  end

  // Previous-cycle copies of the level inputs for edge detection.
  always_ff @(posedge clk7_159) begin
    if (!_reset) begin
      coin_prev   <= 1'b0;
      start_prev  <= 1'b0;
      vblank_prev <= 1'b0;
    end else begin
      coin_prev   <= bus.coin;
      start_prev  <= bus.start;
      vblank_prev <= bus.vblank;
    end
  end

  // Credit bookkeeping: coins add, accepted starts spend.
  always_ff @(posedge clk7_159) begin
    if (!_reset) begin
      credit_cnt <= 4'd0;
    end else begin
`ifdef FREE_PLAY_EN
      if (coin_edge) begin
        credit_cnt <= credit_inc(credit_cnt);
      end
`else
      // A coin and a spend in the same cycle cancel out.
      case ({coin_edge, accept})
        2'b10:   credit_cnt <= credit_inc(credit_cnt);
        2'b01:   credit_cnt <= credit_dec(credit_cnt);
        default: credit_cnt <= credit_cnt;
      endcase
`endif
    end
  end

  // Game state machine with registered score-clear, strobe and mode outputs.
  always_ff @(posedge clk7_159) begin
    if (!_reset) begin
      state       <= ATTRACT;
      timer       <= 8'd0;
      srst_cnt    <= 4'd0;
      point_cnt   <= 1'b0;
      clear       <= 1'b0;
      clear_n     <= 1'b1;
      strobe_l    <= 1'b0;
      strobe_r    <= 1'b0;
      serve_pulse <= 1'b0;
      game_on     <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      strobe_l    <= 1'b0;
      strobe_r    <= 1'b0;
      serve_pulse <= 1'b0;

      case (state)
        ATTRACT: begin
          if (accept) begin
            state    <= START_RST;
            srst_cnt <= 4'd0;
            clear    <= 1'b1;
            clear_n  <= 1'b0;
            game_on  <= 1'b1;
          end
        end

        START_RST: begin
          // clear was raised on entry; drop it after SRST_CYCLES clocks.
          if (srst_cnt == SRST_LAST) begin
            state   <= SERVE_WAIT;
            timer   <= 8'd0;
            clear   <= 1'b0;
            clear_n <= 1'b1;
          end else begin
            srst_cnt <= srst_cnt + 4'd1;
          end
        end

        SERVE_WAIT: begin
          // Misses are ignored here; only frame ticks advance the delay.
          if (frame_tick) begin
            if (timer == SERVE_LAST) begin
              state       <= PLAY;
              timer       <= 8'd0;
              serve_pulse <= 1'b1;
            end else begin
              timer <= timer + 8'd1;
            end
          end
        end

        PLAY: begin
          if (bus.miss) begin
            state     <= POINT;
            point_cnt <= 1'b0;
            strobe_l  <= bus.miss_r;
            strobe_r  <= ~bus.miss_r;
          end
        end

        POINT: begin
          // First clock lets the counters absorb the strobe; stop_g is
          // trusted only on the second clock.
          if (point_cnt) begin
            timer <= 8'd0;
            if (bus.stop_g) begin
              state   <= GAME_OVER;
              game_on <= 1'b0;
            end else begin
              state <= SERVE_WAIT;
            end
          end else begin
            point_cnt <= 1'b1;
          end
        end

        GAME_OVER: begin
          // Scores stay visible; a new game may start straight away.
          if (accept) begin
            state    <= START_RST;
            srst_cnt <= 4'd0;
            clear    <= 1'b1;
            clear_n  <= 1'b0;
            game_on  <= 1'b1;
          end else if (frame_tick) begin
            if (timer == OVER_LAST) begin
              state <= ATTRACT;
              timer <= 8'd0;
            end else begin
              timer <= timer + 8'd1;
            end
          end
        end

        default: begin
          state   <= ATTRACT;
          timer   <= 8'd0;
          clear   <= 1'b0;
          clear_n <= 1'b1;
          game_on <= 1'b0;
        end
      endcase
    end
  end

  assign bus.srst     = clear;
  assign bus._srst    = clear_n;
  assign bus.l        = strobe_l;
  assign bus.r        = strobe_r;
  assign bus.serve    = serve_pulse;
  assign bus._attract = game_on;
  assign bus.credits  = credit_cnt;

endmodule

// File: tb/tb_game_flow_controller.sv
// Self-checking bench for game_flow_controller. A behavioural model built on
// "remaining ticks/clocks" counters and a clamped credit balance predicts
// every output; scenario tasks compare the DUT against it and against fixed
// values taken from the game rules.
module tb_game_flow_controller;

  localparam int SERVE_FRAMES = 60;
  localparam int OVER_FRAMES  = 180;
  localparam int SRST_CYCLES  = 4;
  localparam int CREDIT_MAX   = 9;

`ifdef FREE_PLAY_EN
  localparam bit FREE = 1'b1;
`else
  localparam bit FREE = 1'b0;
`endif

  localparam int PH_IDLE  = 0;
  localparam int PH_CLEAR = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_PLAY  = 3;
  localparam int PH_SCORE = 4;
  localparam int PH_OVER  = 5;

  logic clk7_159 = 1'b0;
  logic _reset;

  game_flow_controller_if bus ();

  game_flow_controller #(
    .SERVE_FRAMES(SERVE_FRAMES),
    .OVER_FRAMES (OVER_FRAMES),
    .SRST_CYCLES (SRST_CYCLES),
    .CREDIT_MAX  (CREDIT_MAX)
  ) dut (
    .clk7_159(clk7_159),
    ._reset  (_reset),
    .bus     (bus)
  );

  always #5 clk7_159 = ~clk7_159;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int m_phase;
  int m_left;
  int m_credits;
  bit m_srst, m_l, m_r, m_serve, m_attr;
  bit m_pc, m_ps, m_pv;
  bit m_tick;

  int vb_phase = 0;

  task automatic model_step();
    bit ce, se, can;
    int bal;
    if (!_reset) begin
      m_phase = PH_IDLE; m_left = 0; m_credits = 0;
      m_srst = 0; m_l = 0; m_r = 0; m_serve = 0; m_attr = 0;
      m_pc = 0; m_ps = 0; m_pv = 0; m_tick = 0;
      return;
    end
    ce     = bus.coin && !m_pc;
    se     = bus.start && !m_ps;
    m_tick = bus.vblank && !m_pv;
    m_pc = bus.coin; m_ps = bus.start; m_pv = bus.vblank;
    can = se && (m_phase == PH_IDLE || m_phase == PH_OVER) && (FREE || m_credits > 0);
    bal = m_credits + (ce ? 1 : 0) - ((can && !FREE) ? 1 : 0);
    m_credits = (bal > CREDIT_MAX) ? CREDIT_MAX : ((bal < 0) ? 0 : bal);
    m_l = 0; m_r = 0; m_serve = 0;
    case (m_phase)
      PH_IDLE: if (can) begin
        m_phase = PH_CLEAR; m_left = SRST_CYCLES; m_srst = 1; m_attr = 1;
      end
      PH_CLEAR: begin
        m_left--;
        if (m_left == 0) begin m_phase = PH_WAIT; m_srst = 0; m_left = SERVE_FRAMES; end
      end
      PH_WAIT: if (m_tick) begin
        m_left--;
        if (m_left == 0) begin m_phase = PH_PLAY; m_serve = 1; end
      end
      PH_PLAY: if (bus.miss) begin
        m_phase = PH_SCORE; m_left = 2; m_l = bus.miss_r; m_r = !bus.miss_r;
      end
      PH_SCORE: begin
        m_left--;
        if (m_left == 0) begin
          if (bus.stop_g) begin m_phase = PH_OVER; m_attr = 0; m_left = OVER_FRAMES; end
          else begin m_phase = PH_WAIT; m_left = SERVE_FRAMES; end
        end
      end
      PH_OVER: begin
        if (can) begin
          m_phase = PH_CLEAR; m_left = SRST_CYCLES; m_srst = 1; m_attr = 1;
        end else if (m_tick) begin
          m_left--;
          if (m_left == 0) m_phase = PH_IDLE;
        end
      end
      default: m_phase = PH_IDLE;
    endcase
  endtask

  function automatic logic [9:0] exp_vec();
    return {m_srst, !m_srst, m_l, m_r, m_serve, m_attr, 4'(m_credits)};
  endfunction

  function automatic logic [9:0] act_vec();
    return {bus.srst, bus._srst, bus.l, bus.r, bus.serve, bus._attract, bus.credits};
  endfunction

  // One clock: model follows the edge, inputs may change on the falling edge.
  task automatic step();
    @(posedge clk7_159);
    model_step();
    @(negedge clk7_159);
    vb_phase   = (vb_phase + 1) % 4;
    bus.vblank = (vb_phase >= 2);
  endtask

  task automatic do_reset();
    _reset = 1'b0;
    bus.coin = 0; bus.start = 0; bus.miss = 0; bus.miss_r = 0; bus.stop_g = 0;
    step();
    step();
    _reset = 1'b1;
  endtask

  task automatic go_play(output bit ok);
    ok = 0;
    bus.coin = 1; step(); bus.coin = 0; step();
    bus.start = 1; step(); bus.start = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (bus.serve) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    _reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.coin = 1'($urandom); bus.start = 1'($urandom); bus.miss = 1'($urandom);
      bus.miss_r = 1'($urandom); bus.stop_g = 1'($urandom);
      step();
      checks++;
      if (act_vec() !== 10'b01_0000_0000) begin
        errors++;
        $display("FAIL reset_values: got %b expected %b", act_vec(), 10'b01_0000_0000);
      end
    end
    bus.coin = 0; bus.start = 0; bus.miss = 0; bus.stop_g = 0;
    _reset = 1'b1;
    step();
    checks++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", act_vec(), exp_vec());
    end
  endtask

  task automatic test_credit_game_start();
    int n;
    int ticks;
    bit got;
    do_reset();
    bus.coin = 1; step();
    checks++;
    if (bus.credits !== 4'd1) begin
      errors++; $display("FAIL coin_credit: got %0d expected 1", bus.credits);
    end
    bus.coin = 0; step();
    bus.start = 1; step();
    checks++;
    if ({bus.srst, bus._srst, bus._attract, bus.credits} !== {3'b101, 4'd0}) begin
      errors++;
      $display("FAIL start_accept: got srst=%b _srst=%b _attract=%b credits=%0d expected 1 0 1 0",
               bus.srst, bus._srst, bus._attract, bus.credits);
    end
    bus.start = 0;
    n = 1;
    for (int i = 0; i < 20 && bus.srst; i++) begin
      step();
      checks++;
      if (bus._srst !== !bus.srst) begin
        errors++; $display("FAIL srst_inverse: got srst=%b _srst=%b", bus.srst, bus._srst);
      end
      if (bus.srst) n++;
    end
    checks++;
    if (n != SRST_CYCLES) begin
      errors++; $display("FAIL srst_width: got %0d expected %0d", n, SRST_CYCLES);
    end
    ticks = 0; got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      step();
      if (m_tick) ticks++;
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL serve_wait_vec: got %b expected %b", act_vec(), exp_vec());
      end
      if (bus.serve) got = 1;
    end
    checks++;
    if (!got || ticks != SERVE_FRAMES) begin
      errors++; $display("FAIL serve_delay: got %0d ticks (seen=%0d) expected %0d", ticks, got, SERVE_FRAMES);
    end
  endtask

  task automatic test_coin_saturation();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      bus.coin = 1; step(); bus.coin = 0; step();
    end
    checks++;
    if (bus.credits !== 4'(CREDIT_MAX)) begin
      errors++; $display("FAIL credit_sat: got %0d expected %0d", bus.credits, CREDIT_MAX);
    end
    do_reset();
    bus.coin = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL coin_held_vec: got %b expected %b", act_vec(), exp_vec());
      end
    end
    bus.coin = 0; step();
    checks++;
    if (bus.credits !== 4'd1) begin
      errors++; $display("FAIL coin_held: got %0d expected 1", bus.credits);
    end
    bus.coin = 1; bus.start = 1; step();
    checks++;
    if ({bus.srst, bus.credits} !== {1'b1, 4'd1}) begin
      errors++; $display("FAIL coin_and_start: got srst=%b credits=%0d expected 1 1", bus.srst, bus.credits);
    end
    bus.coin = 0; bus.start = 0; step();
  endtask

  task automatic test_points();
    bit ok;
    bit got;
    do_reset();
    go_play(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL play_entry: got no serve expected serve"); end
    bus.miss_r = 1; bus.miss = 1;
    checks++;
    if ({bus.l, bus.r} !== 2'b00) begin
      errors++; $display("FAIL miss_cycle: got l=%b r=%b expected 0 0", bus.l, bus.r);
    end
    step();
    checks++;
    if ({bus.l, bus.r, bus.serve} !== 3'b100) begin
      errors++; $display("FAIL left_point: got l=%b r=%b serve=%b expected 1 0 0", bus.l, bus.r, bus.serve);
    end
    step();
    checks++;
    if ({bus.l, bus.r} !== 2'b00) begin
      errors++; $display("FAIL miss_in_point: got l=%b r=%b expected 0 0", bus.l, bus.r);
    end
    bus.miss = 0; step();
    bus.miss = 1; step(); bus.miss = 0;
    checks++;
    if ((act_vec() !== exp_vec()) || ({bus.l, bus.r} !== 2'b00)) begin
      errors++; $display("FAIL miss_in_wait: got %b expected %b", act_vec(), exp_vec());
    end
    got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      step();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL reserve_vec: got %b expected %b", act_vec(), exp_vec());
      end
      if (bus.serve) got = 1;
    end
    bus.miss_r = 0; bus.miss = 1; step(); bus.miss = 0;
    checks++;
    if ({bus.l, bus.r, bus.serve} !== 3'b010) begin
      errors++; $display("FAIL right_point: got l=%b r=%b serve=%b expected 0 1 0", bus.l, bus.r, bus.serve);
    end
    step();
    checks++;
    if ({bus.l, bus.r} !== 2'b00) begin
      errors++; $display("FAIL strobe_width: got l=%b r=%b expected 0 0", bus.l, bus.r);
    end
  endtask

  task automatic test_game_over();
    bit ok;
    int ticks;
    string s;
    do_reset();
    go_play(ok);
    bus.stop_g = 1; bus.miss_r = 1'($urandom); bus.miss = 1; step(); bus.miss = 0;
    step(); step();
    bus.stop_g = 0;
    checks++;
    if ({bus._attract, bus.srst, bus._srst} !== 3'b001 || act_vec() !== exp_vec()) begin
      errors++; $display("FAIL game_over_entry: got %b expected %b", act_vec(), exp_vec());
    end
    ticks = 0;
    for (int i = 0; i < 2000 && ticks < OVER_FRAMES; i++) begin
      step();
      if (m_tick) begin
        ticks++;
        if (ticks == OVER_FRAMES - 1) begin
          s = dut.state.name();
          checks++;
          if (s != "GAME_OVER") begin
            errors++; $display("FAIL over_hold: got %s expected GAME_OVER", s);
          end
        end
      end
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL over_vec: got %b expected %b", act_vec(), exp_vec());
      end
    end
    s = dut.state.name();
    checks++;
    if (s != "ATTRACT") begin
      errors++; $display("FAIL over_to_attract: got %s expected ATTRACT", s);
    end
    do_reset();
    bus.coin = 1; step(); bus.coin = 0; step();
    go_play(ok);
    bus.stop_g = 1; bus.miss = 1; step(); bus.miss = 0;
    step(); step(); bus.stop_g = 0;
    step(); step();
    bus.start = 1; step(); bus.start = 0;
    checks++;
    if ({bus.srst, bus._attract, bus.credits} !== {2'b11, 4'd0}) begin
      errors++; $display("FAIL restart_in_over: got srst=%b _attract=%b credits=%0d expected 1 1 0",
                         bus.srst, bus._attract, bus.credits);
    end
  endtask

  task automatic test_reset_midgame();
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      if (pass == 0) begin
        bus.coin = 1; step(); bus.coin = 0; step();
        bus.start = 1; step(); bus.start = 0;
        for (int i = 0; i < 40; i++) step();
      end else begin
        go_play(ok);
        bus.miss_r = 1'($urandom); bus.miss = 1; step(); bus.miss = 0;
      end
      _reset = 1'b0; step(); _reset = 1'b1;
      checks++;
      if (act_vec() !== 10'b01_0000_0000) begin
        errors++; $display("FAIL midgame_reset_%0d: got %b expected %b", pass, act_vec(), 10'b01_0000_0000);
      end
      for (int i = 0; i < 300; i++) begin
        bus.miss = ($urandom_range(0, 9) == 0); bus.miss_r = 1'($urandom);
        step();
        checks++;
        if ({bus.l, bus.r, bus.serve} !== 3'b000) begin
          errors++; $display("FAIL post_reset_strobe_%0d: got l=%b r=%b serve=%b expected 0 0 0",
                             pass, bus.l, bus.r, bus.serve);
        end
      end
      bus.miss = 0;
    end
  endtask

  task automatic test_start_without_credit();
    do_reset();
    bus.start = 1; step(); bus.start = 0;
    checks++;
`ifdef FREE_PLAY_EN
    if ({bus.srst, bus._attract, bus.credits} !== {2'b11, 4'd0}) begin
      errors++; $display("FAIL free_play_start: got srst=%b _attract=%b credits=%0d expected 1 1 0",
                         bus.srst, bus._attract, bus.credits);
    end
`else
    if ({bus.srst, bus._attract, bus.credits} !== {2'b00, 4'd0}) begin
      errors++; $display("FAIL no_credit_start: got srst=%b _attract=%b credits=%0d expected 0 0 0",
                         bus.srst, bus._attract, bus.credits);
    end
`endif
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) bus.coin = ~bus.coin;
      if ($urandom_range(0, 7) == 0) bus.start = ~bus.start;
      bus.miss   = ($urandom_range(0, 19) == 0);
      bus.miss_r = 1'($urandom);
      bus.stop_g = ($urandom_range(0, 2) == 0);
      _reset     = ($urandom_range(0, 699) != 0);
      step();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_vec @%0d: got %b expected %b", i, act_vec(), exp_vec());
      end
      checks++;
      if ((int'(bus.l) + int'(bus.r) + int'(bus.serve)) > 1) begin
        errors++; $display("FAIL exclusive_strobes @%0d: got l=%b r=%b serve=%b expected at most one",
                           i, bus.l, bus.r, bus.serve);
      end
    end
    _reset = 1'b1;
    bus.miss = 0;
  endtask

  initial begin
    _reset = 1'b0;
    bus.vblank = 0; bus.coin = 0; bus.start = 0;
    bus.miss = 0; bus.miss_r = 0; bus.stop_g = 0;
    @(negedge clk7_159);
    test_reset();
    test_credit_game_start();
    test_coin_saturation();
    test_points();
    test_game_over();
    test_reset_midgame();
    test_start_without_credit();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Clocked sequencer for the Pong score datapath.
- Manages credits and the start request, and clears the score counters at game start.
- Times serve delays, converts ball-miss events into per-player point strobes, and detects end of game from the counters' stop_g.
- Sits between the coin/start inputs, the ball/miss logic and the score counter circuit. Drives that circuit's srst/_srst, l/r and _attract.

Parameters:
- SERVE_FRAMES, 60, frame ticks from entering SERVE_WAIT to the serve pulse (1..255).
- OVER_FRAMES, 180, frame ticks spent in GAME_OVER before returning to ATTRACT (1..255).
- SRST_CYCLES, 4, clocks srst is held high at game start (1..15).
- CREDIT_MAX, 9, saturation value of the credit counter (1..15).

Ports:
- clk7_159  in  1  system clock; the only clock.
- _reset  in  1  synchronous, active-low reset.
- vblank  in  1  vertical blank, level; its rising edge is the frame tick.
- coin  in  1  coin switch, level, already debounced.
- start  in  1  start button, level, already debounced.
- miss  in  1  one-cycle pulse: ball has left the playfield.
- miss_r  in  1  qualifies miss: 1 = exited right edge (left player scores), 0 = exited left edge (right player scores).
- stop_g  in  1  end-of-game flag from the score counters.
- srst  out  1  score clear, active-high.
- _srst  out  1  always the inverse of srst.
- l  out  1  one-cycle point strobe to the left-player counter.
- r  out  1  one-cycle point strobe to the right-player counter.
- serve  out  1  one-cycle pulse launching the ball.
- _attract  out  1  0 = attract mode, 1 = game in progress.
- credits  out  4  current credit count.

Behaviour:
- Reset and clocking: single clock domain; all outputs are registered.
- While _reset=0 at a clock edge: state=ATTRACT, credits=0, srst=0, _srst=1, l=0, r=0, serve=0, _attract=0, all timers=0.
- Reset asserted mid-game aborts immediately, with no strobes issued afterwards.
- Edge detection: coin and start are rising-edge detected against their previous-cycle values. A held level counts once.
- Frame tick: one cycle, on the vblank 0->1 transition.
- Credits:
  - Each coin edge increments credits, saturating at CREDIT_MAX.
  - An accepted start decrements credits.
  - Coin edge and accepted start in the same cycle leave credits unchanged.
  - Start is accepted only when the registered credits >= 1.
- State machine transitions:
  - ATTRACT: _attract=0. Accepted start -> START_RST.
  - START_RST: srst=1 for exactly SRST_CYCLES clocks, then srst=0 -> SERVE_WAIT. _attract=1 from the first START_RST cycle.
  - SERVE_WAIT: counts frame ticks. On the SERVE_FRAMES-th tick, serve=1 for one cycle -> PLAY. miss is ignored here.
  - PLAY: on miss=1, the next cycle pulses l (miss_r=1) or r (miss_r=0) for one cycle -> POINT. Exactly one of l/r ever pulses per miss.
  - POINT: lasts 2 clocks so the counters settle. On the second clock stop_g is sampled: 1 -> GAME_OVER, 0 -> SERVE_WAIT with the timer cleared. A miss during POINT is ignored.
  - GAME_OVER: _attract=0 and scores are retained (no srst). Counts OVER_FRAMES frame ticks -> ATTRACT. An accepted start during GAME_OVER -> START_RST immediately.
- Output timing:
  - l, r and serve are never high in the same cycle.
  - Latency from miss to point strobe is exactly 1 clock.
- Start outside ATTRACT/GAME_OVER is ignored and does not consume a credit.
- Timer details: timers are 8 bits and never wrap. A timer clears on every entry to its state.

Optional Feature:
- Macro FREE_PLAY_EN.
- Defined: start is accepted whenever the state is ATTRACT or GAME_OVER, regardless of credits. Credits never decrement but still count coins, saturating.
- Undefined: the credit rules above apply.

Test Plan:
- Reset, coin edge x1, start edge -> credits 0->1->0; srst high for exactly 4 clocks with _srst its inverse; _attract=1; serve pulse 60 frame ticks after srst falls.
- 12 coin edges -> credits saturates at 9. Coin held high for 100 clocks -> only +1. Coin edge and start edge in the same cycle with credits=1 -> credits stays 1 and the game starts.
- In PLAY, miss with miss_r=1 -> l=1 exactly 1 clock later for 1 clock, r=0. With miss_r=0 -> r pulses. A second miss during POINT/SERVE_WAIT -> no strobe.
- stop_g=1 on the POINT sample -> GAME_OVER, _attract=0, no srst. After 180 frame ticks -> ATTRACT. An accepted start inside GAME_OVER -> START_RST at once.
- _reset=0 during SERVE_WAIT and during a POINT cycle -> next edge shows all reset values; no l/r/serve afterwards.
- FREE_PLAY_EN defined, credits=0, start edge -> game starts, credits remains 0.
